// File: rtl/conn_table_loader.sv
// Walks the config reader's connection records into a QP-indexed table and
// answers single-cycle registered lookups of a local QP to its peer addressing.
module conn_table_loader #(
    parameter int MAX_ENTRIES = 64,
    parameter int IDX_W       = 6,
    parameter int TIMEOUT     = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    input  logic              cfg_error,
    input  logic              cfg_busy,
    input  logic [31:0]       cfg_num_conns,
    input  logic              load_start,
    output logic              rd_req,
    output logic [IDX_W-1:0]  rd_index,
    input  logic              rd_valid,
    input  logic [15:0]       rd_my_qp,
    input  logic [15:0]       rd_peer_qp,
    input  logic [31:0]       rd_peer_ip,
    input  logic [15:0]       rd_peer_port,
    input  logic [47:0]       rd_peer_mac,
    input  logic              rd_up,
    input  logic              lkp_req,
    input  logic [15:0]       lkp_qp,
    output logic              lkp_ack,
    output logic              lkp_hit,
    output logic [IDX_W-1:0]  lkp_index,
    output logic [15:0]       lkp_peer_qp,
    output logic [15:0]       lkp_peer_port,
    output logic [31:0]       lkp_peer_ip,
    output logic [47:0]       lkp_peer_mac,
    output logic              table_ready,
    output logic              load_busy,
    output logic              load_error,
    output logic [IDX_W:0]    entry_count
);

    localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDX_W-1:0] IDX_ONE = 1;
    localparam logic [IDX_W:0]   CNT_ONE = 1;
    localparam logic [TMR_W-1:0] TMR_ONE = 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, READY, ERR} state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  last_idx;
    logic [TMR_W-1:0]  timer;

    logic [MAX_ENTRIES-1:0] ent_valid;
    logic [MAX_ENTRIES-1:0] ent_up;
    logic [15:0]            ent_my_qp   [MAX_ENTRIES];
    logic [15:0]            ent_peer_qp [MAX_ENTRIES];
    logic [15:0]            ent_port    [MAX_ENTRIES];
    logic [31:0]            ent_ip      [MAX_ENTRIES];
    logic [47:0]            ent_mac     [MAX_ENTRIES];

    logic              start_ok;
    logic              match_hit;
    logic [IDX_W-1:0]  match_idx;

    assign rd_index = idx;
    assign start_ok = load_start && cfg_valid && !cfg_error &&
                      (state == IDLE || state == READY || state == ERR);

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        for (int i = MAX_ENTRIES - 1; i >= 0; i--) begin
            if (ent_valid[i] && ent_up[i] && ent_my_qp[i] == lkp_qp) begin
                match_hit = 1'b1;
                match_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            last_idx    <= '0;
            timer       <= '0;
            rd_req      <= 1'b0;
            table_ready <= 1'b0;
            load_busy   <= 1'b0;
            load_error  <= 1'b0;
            entry_count <= '0;
            ent_valid   <= '0;
            ent_up      <= '0;
            for (int i = 0; i < MAX_ENTRIES; i++) begin
                ent_my_qp[i]   <= '0;
                ent_peer_qp[i] <= '0;
                ent_port[i]    <= '0;
                ent_ip[i]      <= '0;
                ent_mac[i]     <= '0;
            end
        end else begin
            rd_req <= 1'b0;
            case (state)
                IDLE, READY, ERR: begin
                    if (start_ok) begin
                        ent_valid   <= '0;
                        idx         <= '0;
                        timer       <= '0;
                        entry_count <= '0;
                        table_ready <= 1'b0;
                        load_error  <= 1'b0;
                        last_idx    <= IDX_W'(cfg_num_conns - 32'd1);
                        if (cfg_num_conns == 32'd0) begin
                            state       <= READY;
                            table_ready <= 1'b1;
                        end else if (cfg_num_conns > 32'(MAX_ENTRIES)) begin
                            state      <= ERR;
                            load_error <= 1'b1;
                        end else begin
                            state     <= ISSUE;
                            load_busy <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (!cfg_busy) begin
                        rd_req <= 1'b1;
                        timer  <= '0;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (rd_valid) begin
                        ent_valid[idx]   <= 1'b1;
                        ent_up[idx]      <= rd_up;
                        ent_my_qp[idx]   <= rd_my_qp;
                        ent_peer_qp[idx] <= rd_peer_qp;
                        ent_port[idx]    <= rd_peer_port;
                        ent_ip[idx]      <= rd_peer_ip;
                        ent_mac[idx]     <= rd_peer_mac;
                        entry_count      <= entry_count + CNT_ONE;
                        if (idx == last_idx) begin
                            state       <= READY;
                            table_ready <= 1'b1;
                            load_busy   <= 1'b0;
                        end else begin
                            idx   <= idx + IDX_ONE;
                            state <= ISSUE;
                        end
                    end else if (timer == TMR_LAST) begin
                        state      <= ERR;
                        load_error <= 1'b1;
                        load_busy  <= 1'b0;
                    end else begin
                        timer <= timer + TMR_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Results are forced to zero unless a lookup hits in a fully loaded table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lkp_ack       <= 1'b0;
            lkp_hit       <= 1'b0;
            lkp_index     <= '0;
            lkp_peer_qp   <= '0;
            lkp_peer_port <= '0;
            lkp_peer_ip   <= '0;
            lkp_peer_mac  <= '0;
        end else begin
            lkp_ack       <= lkp_req;
            lkp_hit       <= 1'b0;
            lkp_index     <= '0;
            lkp_peer_qp   <= '0;
            lkp_peer_port <= '0;
            lkp_peer_ip   <= '0;
            lkp_peer_mac  <= '0;
            if (lkp_req && state == READY && match_hit) begin
                lkp_hit       <= 1'b1;
                lkp_index     <= match_idx;
                lkp_peer_qp   <= ent_peer_qp[match_idx];
                lkp_peer_port <= ent_port[match_idx];
                lkp_peer_ip   <= ent_ip[match_idx];
                lkp_peer_mac  <= ent_mac[match_idx];
            end
        end
    end

endmodule

// File: tb/tb_conn_table_loader.sv
// Randomized scoreboard bench for conn_table_loader: a reader model answers
// rd_req, and lookups are checked against a list-search model of loaded records.
module tb_conn_table_loader;

    localparam int MAX_ENTRIES = 64;
    localparam int IDX_W       = 6;
    localparam int TIMEOUT     = 1024;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_valid = 1'b0, cfg_error = 1'b0, cfg_busy = 1'b0;
    logic [31:0]       cfg_num_conns = '0;
    logic              load_start = 1'b0;
    logic              rd_req;
    logic [IDX_W-1:0]  rd_index;
    logic              rd_valid = 1'b0;
    logic [15:0]       rd_my_qp = '0, rd_peer_qp = '0, rd_peer_port = '0;
    logic [31:0]       rd_peer_ip = '0;
    logic [47:0]       rd_peer_mac = '0;
    logic              rd_up = 1'b0;
    logic              lkp_req = 1'b0;
    logic [15:0]       lkp_qp = '0;
    logic              lkp_ack, lkp_hit;
    logic [IDX_W-1:0]  lkp_index;
    logic [15:0]       lkp_peer_qp, lkp_peer_port;
    logic [31:0]       lkp_peer_ip;
    logic [47:0]       lkp_peer_mac;
    logic              table_ready, load_busy, load_error;
    logic [IDX_W:0]    entry_count;

    conn_table_loader #(.MAX_ENTRIES(MAX_ENTRIES), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_error(cfg_error),
        .cfg_busy(cfg_busy), .cfg_num_conns(cfg_num_conns), .load_start(load_start),
        .rd_req(rd_req), .rd_index(rd_index), .rd_valid(rd_valid), .rd_my_qp(rd_my_qp),
        .rd_peer_qp(rd_peer_qp), .rd_peer_ip(rd_peer_ip), .rd_peer_port(rd_peer_port),
        .rd_peer_mac(rd_peer_mac), .rd_up(rd_up), .lkp_req(lkp_req), .lkp_qp(lkp_qp),
        .lkp_ack(lkp_ack), .lkp_hit(lkp_hit), .lkp_index(lkp_index),
        .lkp_peer_qp(lkp_peer_qp), .lkp_peer_port(lkp_peer_port),
        .lkp_peer_ip(lkp_peer_ip), .lkp_peer_mac(lkp_peer_mac),
        .table_ready(table_ready), .load_busy(load_busy), .load_error(load_error),
        .entry_count(entry_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              hit;
        logic [IDX_W-1:0]  index;
        logic [15:0]       peer_qp;
        logic [15:0]       peer_port;
        logic [31:0]       peer_ip;
        logic [47:0]       peer_mac;
    } lkp_exp_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rd_exp = 0;
    int req_count = 0;
    int last_req_cyc = 0;
    int withhold_from = MAX_ENTRIES;
    bit withhold_all = 1'b0;
    bit model_ready = 1'b0;
    int model_n = 0;

    logic [15:0] rec_my_qp [MAX_ENTRIES];
    logic [15:0] rec_peer_qp [MAX_ENTRIES];
    logic [15:0] rec_port [MAX_ENTRIES];
    logic [31:0] rec_ip [MAX_ENTRIES];
    logic [47:0] rec_mac [MAX_ENTRIES];
    logic        rec_up [MAX_ENTRIES];

    lkp_exp_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // First loaded, linked-up record whose local QP matches wins.
    function automatic lkp_exp_t model_lookup(input logic [15:0] q);
        lkp_exp_t e = '0;
        if (model_ready) begin
            for (int i = 0; i < model_n; i++) begin
                if (rec_up[i] && rec_my_qp[i] == q) begin
                    e.hit = 1'b1;
                    e.index = IDX_W'(i);
                    e.peer_qp = rec_peer_qp[i];
                    e.peer_port = rec_port[i];
                    e.peer_ip = rec_ip[i];
                    e.peer_mac = rec_mac[i];
                    break;
                end
            end
        end
        return e;
    endfunction

    // Reader model: answers each rd_req after a random delay unless withheld.
    initial begin
        int d;
        int ri;
        forever begin
            @(negedge clk);
            rd_valid = 1'b0;
            if (rd_req) begin
                check("rd_index", 64'(rd_index), 64'(rd_exp));
                rd_exp++;
                req_count++;
                last_req_cyc = cyc;
                ri = int'(rd_index);
                if (!withhold_all && ri < withhold_from) begin
                    d = $urandom_range(0, 3);
                    repeat (d) @(negedge clk);
                    rd_my_qp = rec_my_qp[ri];
                    rd_peer_qp = rec_peer_qp[ri];
                    rd_peer_port = rec_port[ri];
                    rd_peer_ip = rec_ip[ri];
                    rd_peer_mac = rec_mac[ri];
                    rd_up = rec_up[ri];
                    rd_valid = 1'b1;
                end
            end
        end
    end

    // Lookup monitor: every ack is matched against the oldest queued expectation.
    initial begin
        lkp_exp_t e;
        forever begin
            @(negedge clk);
            if (lkp_ack) begin
                if (exp_q.size() == 0) begin
                    check("lkp_unexpected_ack", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("lkp_hit", 64'(lkp_hit), 64'(e.hit));
                    check("lkp_index", 64'(lkp_index), 64'(e.index));
                    check("lkp_peer_qp", 64'(lkp_peer_qp), 64'(e.peer_qp));
                    check("lkp_peer_port", 64'(lkp_peer_port), 64'(e.peer_port));
                    check("lkp_peer_ip", 64'(lkp_peer_ip), 64'(e.peer_ip));
                    check("lkp_peer_mac", 64'(lkp_peer_mac), 64'(e.peer_mac));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic fill_records(input int n, input logic [15:0] base, input int span, input bit rand_up);
        logic [63:0] m;
        for (int i = 0; i < n; i++) begin
            rec_my_qp[i] = base + 16'($urandom_range(0, span));
            rec_up[i] = rand_up ? 1'($urandom_range(0, 1)) : 1'b1;
            rec_peer_qp[i] = 16'($urandom);
            rec_port[i] = 16'($urandom);
            rec_ip[i] = $urandom;
            m = {$urandom, $urandom};
            rec_mac[i] = m[47:0];
        end
    endtask

    task automatic start_load(input int n);
        cfg_valid = 1'b1;
        cfg_error = 1'b0;
        cfg_num_conns = 32'(n);
        load_start = 1'b1;
        rd_exp = 0;
        req_count = 0;
        model_ready = 1'b0;
        model_n = 0;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    // res: 1 = table_ready, 2 = load_error
    task automatic wait_done(output int res);
        res = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (table_ready) begin res = 1; break; end
            if (load_error) begin res = 2; break; end
        end
        if (res == 0) check("wait_done_timeout", 64'd1, 64'd0);
    endtask

    task automatic check_output(input string tag, input int n, input int exp_res,
                                input int exp_cnt, input int exp_reqs);
        int res;
        wait_done(res);
        check({tag, "_result"}, 64'(res), 64'(exp_res));
        check({tag, "_entry_count"}, 64'(entry_count), 64'(exp_cnt));
        check({tag, "_rd_reqs"}, 64'(req_count), 64'(exp_reqs));
        check({tag, "_load_busy"}, 64'(load_busy), 64'd0);
        model_ready = (res == 1);
        model_n = (res == 1) ? n : 0;
    endtask

    task automatic lookup(input logic [15:0] q);
        lkp_req = 1'b1;
        lkp_qp = q;
        exp_q.push_back(model_lookup(q));
        @(negedge clk);
    endtask

    task automatic lookup_idle();
        lkp_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_table_ready"}, 64'(table_ready), 64'd0);
        check({tag, "_load_busy"}, 64'(load_busy), 64'd0);
        check({tag, "_load_error"}, 64'(load_error), 64'd0);
        check({tag, "_entry_count"}, 64'(entry_count), 64'd0);
        check({tag, "_rd_req"}, 64'(rd_req), 64'd0);
        check({tag, "_rd_index"}, 64'(rd_index), 64'd0);
        check({tag, "_lkp_ack"}, 64'(lkp_ack), 64'd0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // load_start without a valid, error-free header is ignored
        cfg_num_conns = 32'd3;
        cfg_valid = 1'b0;
        load_start = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_error = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        cfg_error = 1'b0;
        repeat (4) @(negedge clk);
        check("ignored_start_busy", 64'(load_busy), 64'd0);
        check("ignored_start_reqs", 64'(req_count), 64'd0);

        // normal load, held off by cfg_busy at first
        fill_records(3, 16'h0100, 0, 1'b0);
        for (int i = 0; i < 3; i++) rec_my_qp[i] = 16'h0100 + 16'(i);
        cfg_busy = 1'b1;
        start_load(3);
        repeat (3) @(negedge clk);
        check("busy_holds_req", 64'(req_count), 64'd0);
        check("busy_load_busy", 64'(load_busy), 64'd1);
        cfg_busy = 1'b0;
        check_output("normal", 3, 1, 3, 3);
        lookup(16'h0101);
        lookup(16'h0200);
        lookup(16'h0100);
        lookup(16'h0102);
        lookup_idle();

        // down entry and duplicate QPs; also a lookup while the load is running
        fill_records(3, 16'h0100, 0, 1'b0);
        rec_up[0] = 1'b0;
        rec_my_qp[1] = 16'h0105;
        rec_my_qp[2] = 16'h0105;
        start_load(3);
        lookup(16'h0100);
        lookup_idle();
        check_output("dup", 3, 1, 3, 3);
        lookup(16'h0100);
        lookup(16'h0105);
        lookup_idle();

        // boundary counts
        start_load(0);
        check_output("n0", 0, 1, 0, 0);
        lookup(16'h0105);
        lookup_idle();
        start_load(65);
        check_output("n65", 65, 2, 0, 0);
        lookup(16'h0105);
        lookup_idle();
        fill_records(MAX_ENTRIES, 16'h0400, 31, 1'b1);
        start_load(MAX_ENTRIES);
        check_output("n64", MAX_ENTRIES, 1, MAX_ENTRIES, MAX_ENTRIES);
        for (int i = 0; i < 10; i++) lookup(16'h0400 + 16'($urandom_range(0, 33)));
        lookup(rec_my_qp[MAX_ENTRIES-1]);
        lookup_idle();

        // reader timeout, then recovery with a responsive reader
        withhold_all = 1'b1;
        fill_records(2, 16'h0500, 1, 1'b0);
        start_load(2);
        check_output("timeout", 2, 2, 0, 1);
        check("timeout_cycles", 64'(cyc - last_req_cyc), 64'(TIMEOUT));
        withhold_all = 1'b0;
        start_load(2);
        check_output("recover", 2, 1, 2, 2);
        lookup(16'h0500);
        lookup(16'h0501);
        lookup_idle();

        // reset while waiting on index 1, then reload with fresh records
        fill_records(3, 16'h0600, 0, 1'b0);
        withhold_from = 1;
        start_load(3);
        n = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (rd_req && rd_index == 6'd1) begin n = 1; break; end
        end
        check("reach_wait_idx1", 64'(n), 64'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midload_reset");
        model_ready = 1'b0;
        withhold_from = MAX_ENTRIES;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fill_records(3, 16'h0700, 0, 1'b0);
        for (int i = 0; i < 3; i++) rec_my_qp[i] = 16'h0700 + 16'(i);
        start_load(3);
        check_output("reload", 3, 1, 3, 3);
        lookup(16'h0600);
        lookup(16'h0702);
        lookup_idle();

        // randomized loads with dense QP collisions and random link state
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, 12);
            fill_records(n, 16'h0300, 7, 1'b1);
            start_load(n);
            check_output("rand", n, 1, n, n);
            for (int k = 0; k < 8; k++) lookup(16'h0300 + 16'($urandom_range(0, 8)));
            lookup_idle();
        end

        check("lkp_queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
